// File: rtl/menu_mode_ctrl.sv
// Mode-select menu sequencer: debounced buttons, blinking cursor, mode latch, start pulse.
// Optional build macro: MENU_WRAP_EN (cursor wraps at row ends instead of saturating).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   frame_tick          one-cycle pulse per video frame (all timing in frames)
//   menu_active         menu screen is shown
//   btn_up/down/sel     raw asynchronous buttons
//   game_over           one-cycle pulse from game core
//   cursor_y_off[9:0]   registered cursor row offset
//   cursor_on           draw cursor this frame
//   game_mode           latched choice, 0=SCORE 1=TIME
//   start_game          one-cycle start pulse
//   state_o[1:0]        FSM state for debug
module menu_mode_ctrl #(
  parameter int unsigned DEB_FRAMES     = 2,
  parameter int unsigned BLINK_FRAMES   = 16,
  parameter int unsigned CONFIRM_FRAMES = 30,
  parameter logic [9:0]  ROW_SCORE_Y    = 10'd100,
  parameter logic [9:0]  ROW_TIME_Y     = 10'd180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       menu_active,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  input  logic       game_over,
  output logic [9:0] cursor_y_off,
  output logic       cursor_on,
  output logic       game_mode,
  output logic       start_game,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MENU    = 2'd1,
    CONFIRM = 2'd2,
    RUN     = 2'd3
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_FRAMES - 1);
  localparam logic [7:0] BLK_LAST = 8'(BLINK_FRAMES - 1);
  localparam logic [7:0] CNF_LAST = 8'(CONFIRM_FRAMES - 1);

  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] stab;
  logic [2:0] stab_d;
  logic [7:0] deb_cnt [3];
  logic [2:0] evt;
  logic       up_evt;
  logic       down_evt;
  logic       sel_evt;

  assign raw      = {btn_sel, btn_down, btn_up};
  assign evt      = stab & ~stab_d;
  assign up_evt   = evt[0];
  assign down_evt = evt[1];
  assign sel_evt  = evt[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stab   <= '0;
      stab_d <= '0;
      for (int i = 0; i < 3; i++)
        deb_cnt[i] <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stab_d <= stab;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stab[i]) begin
          deb_cnt[i] <= '0;
        end else if (frame_tick) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stab[i]    <= ~stab[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  state_t     state;
  state_t     state_n;
  logic       sel_row;
  logic       sel_row_n;
  logic       game_mode_n;
  logic       cursor_on_n;
  logic       start_n;
  logic [7:0] blink_cnt;
  logic [7:0] blink_n;
  logic [7:0] conf_cnt;
  logic [7:0] conf_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sel_row      <= 1'b0;
      game_mode    <= 1'b0;
      cursor_on    <= 1'b0;
      start_game   <= 1'b0;
      blink_cnt    <= '0;
      conf_cnt     <= '0;
      cursor_y_off <= ROW_SCORE_Y;
    end else begin
      state        <= state_n;
      sel_row      <= sel_row_n;
      game_mode    <= game_mode_n;
      cursor_on    <= cursor_on_n;
      start_game   <= start_n;
      blink_cnt    <= blink_n;
      conf_cnt     <= conf_n;
      cursor_y_off <= sel_row ? ROW_TIME_Y : ROW_SCORE_Y;
    end
  end

  always_comb begin
    state_n     = state;
    sel_row_n   = sel_row;
    game_mode_n = game_mode;
    cursor_on_n = cursor_on;
    start_n     = 1'b0;
    blink_n     = blink_cnt;
    conf_n      = conf_cnt;
    unique case (state)
      IDLE: begin
        cursor_on_n = 1'b0;
        if (menu_active) begin
          state_n     = MENU;
          blink_n     = '0;
          cursor_on_n = 1'b1;
        end
      end
      MENU: begin
        if (!menu_active) begin
          state_n     = IDLE;
          cursor_on_n = 1'b0;
        end else if (sel_evt) begin
          state_n     = CONFIRM;
          game_mode_n = sel_row;
          conf_n      = '0;
          cursor_on_n = 1'b1;
        end else begin
`ifdef MENU_WRAP_EN
          if (up_evt ^ down_evt)
            sel_row_n = ~sel_row;
`else
          if (up_evt && !down_evt)
            sel_row_n = 1'b0;
          else if (down_evt && !up_evt)
            sel_row_n = 1'b1;
`endif
          if (frame_tick) begin
            if (blink_cnt == BLK_LAST) begin
              blink_n     = '0;
              cursor_on_n = ~cursor_on;
            end else begin
              blink_n = blink_cnt + 8'd1;
            end
          end
        end
      end
      CONFIRM: begin
        cursor_on_n = 1'b1;
        if (!menu_active) begin
          state_n     = IDLE;
          cursor_on_n = 1'b0;
        end else if (frame_tick) begin
          if (conf_cnt == CNF_LAST) begin
            state_n     = RUN;
            start_n     = 1'b1;
            cursor_on_n = 1'b0;
            conf_n      = '0;
          end else begin
            conf_n = conf_cnt + 8'd1;
          end
        end
      end
      RUN: begin
        cursor_on_n = 1'b0;
        if (game_over) begin
          if (menu_active) begin
            state_n     = MENU;
            blink_n     = '0;
            cursor_on_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_menu_mode_ctrl.sv
// Bench for menu_mode_ctrl: directed plan steps plus random play,
// all compared against a frame-level behavioural model.
module tb_menu_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       menu_active = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_sel = 1'b0;
  logic       game_over = 1'b0;
  logic [9:0] cursor_y_off;
  logic       cursor_on;
  logic       game_mode;
  logic       start_game;
  logic [1:0] state_o;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  menu_mode_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .menu_active  (menu_active),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_sel      (btn_sel),
    .game_over    (game_over),
    .cursor_y_off (cursor_y_off),
    .cursor_on    (cursor_on),
    .game_mode    (game_mode),
    .start_game   (start_game),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: screen mode as an int, buttons as a 2-deep
  // delay list plus a "held frames" count toward acceptance.
  int m_mode;
  int m_row;
  int m_choice;
  bit m_cur;
  bit m_start;
  int m_yoff;
  int m_blink;
  int m_conf;
  bit m_pipe [3][2];
  bit m_level [3];
  bit m_fresh [3];
  int m_held [3];

  function automatic int row_y(input int r);
    return (r != 0) ? 180 : 100;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_row = 0; m_choice = 0;
    m_cur = 0; m_start = 0; m_yoff = 100;
    m_blink = 0; m_conf = 0;
    for (int i = 0; i < 3; i++) begin
      m_pipe[i][0] = 0; m_pipe[i][1] = 0;
      m_level[i] = 0; m_fresh[i] = 0; m_held[i] = 0;
    end
  endtask

  task automatic model_step(input bit ft, input bit ma,
                            input bit go, input bit raw [3]);
    bit up, dn, sl;
    up = m_fresh[0]; dn = m_fresh[1]; sl = m_fresh[2];
    m_start = 0;
    m_yoff = row_y(m_row);
    if (m_mode == 0) begin
      m_cur = 0;
      if (ma) begin m_mode = 1; m_blink = 0; m_cur = 1; end
    end else if (m_mode == 1) begin
      if (!ma) begin
        m_mode = 0; m_cur = 0;
      end else if (sl) begin
        m_mode = 2; m_choice = m_row; m_conf = 0; m_cur = 1;
      end else begin
        if (up != dn) begin
`ifdef MENU_WRAP_EN
          m_row = 1 - m_row;
`else
          m_row = up ? 0 : 1;
`endif
        end
        if (ft) begin
          m_blink++;
          if (m_blink == 16) begin m_blink = 0; m_cur = !m_cur; end
        end
      end
    end else if (m_mode == 2) begin
      m_cur = 1;
      if (!ma) begin
        m_mode = 0; m_cur = 0;
      end else if (ft) begin
        m_conf++;
        if (m_conf == 30) begin
          m_mode = 3; m_start = 1; m_cur = 0; m_conf = 0;
        end
      end
    end else begin
      m_cur = 0;
      if (go) begin
        if (ma) begin m_mode = 1; m_blink = 0; m_cur = 1; end
        else m_mode = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      bit was;
      was = m_level[i];
      if (m_pipe[i][1] == m_level[i]) m_held[i] = 0;
      else if (ft) begin
        m_held[i]++;
        if (m_held[i] == 2) begin
          m_level[i] = !m_level[i]; m_held[i] = 0;
        end
      end
      m_fresh[i] = m_level[i] && !was;
      m_pipe[i][1] = m_pipe[i][0];
      m_pipe[i][0] = raw[i];
    end
  endtask

  task automatic step(input bit ft);
    bit raw [3];
    frame_tick = ft;
    raw[0] = btn_up; raw[1] = btn_down; raw[2] = btn_sel;
    @(posedge clk);
    model_step(ft, menu_active, game_over, raw);
    #1;
    if (start_game) starts++;
    chk("state", 32'(state_o), 32'(m_mode));
    chk("yoff", 32'(cursor_y_off), 32'(m_yoff));
    chk("cursor_on", 32'(cursor_on), 32'(m_cur));
    chk("mode", 32'(game_mode), 32'(m_choice));
    chk("start", 32'(start_game), 32'(m_start));
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1); step(1'b0); step(1'b0);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_state", 32'(state_o), 0);
    chk("rst_yoff", 32'(cursor_y_off), 100);
    chk("rst_cur", 32'(cursor_on), 0);
    chk("rst_mode", 32'(game_mode), 0);
    chk("rst_start", 32'(start_game), 0);
  endtask

  int s0;
  int guard;

  initial begin
    model_reset();
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;

    menu_active = 1'b1;
    step(1'b0);
    chk("enter_menu", 32'(state_o), 1);
    chk("enter_cur", 32'(cursor_on), 1);
    frames(16);
    chk("blink_off", 32'(cursor_on), 0);
    frames(16);
    chk("blink_on", 32'(cursor_on), 1);

    btn_down = 1'b1; frames(3);
    btn_down = 1'b0; frames(3);
    chk("down_row", 32'(cursor_y_off), 180);

    btn_down = 1'b1; frames(1);
    btn_down = 1'b0; frames(3);
    btn_up = 1'b1; frames(1);
    btn_up = 1'b0; frames(3);
    chk("glitch_row", 32'(cursor_y_off), 180);

    btn_up = 1'b1; btn_down = 1'b1; frames(3);
    btn_up = 1'b0; btn_down = 1'b0; frames(3);
    chk("updown_row", 32'(cursor_y_off), 180);

    s0 = starts;
    btn_sel = 1'b1; frames(3);
    btn_sel = 1'b0;
    chk("sel_state", 32'(state_o), 2);
    chk("sel_mode", 32'(game_mode), 1);
    frames(35);
    chk("start_once", 32'(starts - s0), 1);
    chk("run_state", 32'(state_o), 3);

    game_over = 1'b1; step(1'b0);
    game_over = 1'b0; step(1'b0);
    chk("back_menu", 32'(state_o), 1);

    btn_up = 1'b1; frames(3);
    btn_up = 1'b0; frames(3);
    chk("up_row", 32'(cursor_y_off), 100);
    btn_sel = 1'b1; btn_down = 1'b1; frames(3);
    btn_sel = 1'b0; btn_down = 1'b0;
    chk("seldn_state", 32'(state_o), 2);
    chk("seldn_mode", 32'(game_mode), 0);
    s0 = starts;
    frames(8);
    menu_active = 1'b0; step(1'b0);
    chk("abort_state", 32'(state_o), 0);
    frames(30);
    chk("abort_nostart", 32'(starts - s0), 0);

    menu_active = 1'b1;
    btn_sel = 1'b1; frames(3);
    btn_sel = 1'b0;
    guard = 0;
    while (state_o != 2'd3 && guard < 200) begin
      frames(1); guard++;
    end
    chk("reach_run", 32'(state_o), 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0);
    btn_up = 1'b1; frames(3);
    btn_up = 1'b0; frames(3);
`ifdef MENU_WRAP_EN
    chk("wrap_up", 32'(cursor_y_off), 180);
`else
    chk("sat_up", 32'(cursor_y_off), 100);
`endif

    for (int c = 0; c < 12000; c++) begin
      if ($urandom_range(0, 39) == 0) btn_up = ~btn_up;
      if ($urandom_range(0, 39) == 0) btn_down = ~btn_down;
      if ($urandom_range(0, 59) == 0) btn_sel = ~btn_sel;
      if ($urandom_range(0, 799) == 0) menu_active = ~menu_active;
      game_over = ($urandom_range(0, 299) == 0);
      step($urandom_range(0, 2) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
